// File: rtl/dram_line_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dram_pkg
// Description : Shared types and constants for the DRAM line responder.
//               Holds the FSM state encoding, line offset width and the
//               latency counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package dram_pkg;

    // Responder FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        ACK    = 2'd3
    } state_t;

    // 32-byte lines: the low five address bits select a byte inside a line
    localparam int LINE_OFFSET_BITS = 5;

    // Latency counter width; holds values up to 255
    localparam int CNT_WIDTH = 8;

endpackage : dram_pkg
`default_nettype wire

// File: rtl/dram_line_responder_line_store.sv
`default_nettype none
// ============================================================================
// Module      : line_store
// Description : Single-port synchronous line storage. One access per cycle
//               when en is high: a write when we is high, otherwise a read
//               into the registered rdata. rdata holds between reads and is
//               the only state cleared by reset; array contents survive reset.
// Revision    : 1.0 - initial release
// ============================================================================
module line_store #(
    parameter int MEM_LINES  = 1024,
    parameter int DATA_WIDTH = 256
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         we,
    input  logic [$clog2(MEM_LINES)-1:0] index,
    input  logic [DATA_WIDTH-1:0]        wdata,
    output logic [DATA_WIDTH-1:0]        rdata
);

    logic [DATA_WIDTH-1:0] r_mem [MEM_LINES];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Array write; suppressed while reset is asserted so an aborted access never lands
    always_ff @(posedge clk) begin
        if (rst_n && en && we) begin
            r_mem[index] <= wdata;
        end
    end

    // Registered read port; keeps the last read line until the next read
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (en && !we) begin
            r_rdata <= r_mem[index];
        end
    end

    assign rdata = r_rdata;

endmodule : line_store
`default_nettype wire

// File: rtl/dram_line_responder.sv
`default_nettype none
// ============================================================================
// Module      : dram_line_responder
// Description : Memory-side responder for the L1 DRAM interface. Accepts one
//               cs/we line request at a time, waits a fixed latency, performs
//               a 256-bit line read or write on internal storage and pulses
//               ack_o for one cycle (ack in cycle T0+LATENCY+1).
//               Optional build macro DRAM_LINE_RESPONDER_PROTOCOL_CHECK_EN
//               adds a sticky err_o flag for requester protocol violations.
// Revision    : 1.0 - initial release
// ============================================================================
module dram_line_responder
    import dram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int MEM_DATA_WIDTH = 256,
    parameter int MEM_LINES      = 1024,
    parameter int LATENCY        = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ADDR_WIDTH-1:0]     addr_i,
    input  logic                      cs_i,
    input  logic                      we_i,
    input  logic [MEM_DATA_WIDTH-1:0] data_i,
`ifdef DRAM_LINE_RESPONDER_PROTOCOL_CHECK_EN
    output logic                      err_o,
`endif
    output logic                      ack_o,
    output logic [MEM_DATA_WIDTH-1:0] data_o
);

    localparam int                   C_IDX_W    = $clog2(MEM_LINES);
    localparam int                   C_IDX_TOP  = LINE_OFFSET_BITS + C_IDX_W;
    localparam logic [CNT_WIDTH-1:0] C_CNT_LOAD = CNT_WIDTH'(LATENCY - 1);

    state_t                    r_state;
    logic [CNT_WIDTH-1:0]      r_cnt;
    logic                      r_ack;
    logic [C_IDX_W-1:0]        r_index;
    logic                      r_we;
    logic [MEM_DATA_WIDTH-1:0] r_wdata;

    logic [C_IDX_W-1:0]        w_index;
    logic                      w_store_en;
    logic [MEM_DATA_WIDTH-1:0] w_rdata;

    // Line index: byte offset below, aliasing address bits above are dropped
    assign w_index = addr_i[C_IDX_TOP-1:LINE_OFFSET_BITS];

    // Byte-offset bits and aliasing high bits play no part in the access
    logic w_unused_addr_lo;
    assign w_unused_addr_lo = ^addr_i[LINE_OFFSET_BITS-1:0];

    generate
        if (ADDR_WIDTH > C_IDX_TOP) begin : g_addr_hi
            logic w_unused_addr_hi;
            assign w_unused_addr_hi = ^addr_i[ADDR_WIDTH-1:C_IDX_TOP];
        end
    endgenerate

    // Request FSM: accept, count down the latency, access, one-cycle ack
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_index <= '0;
            r_we    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ack <= 1'b0;
                    if (cs_i) begin
                        r_index <= w_index;
                        r_we    <= we_i;
                        r_cnt   <= C_CNT_LOAD;
                        r_state <= (LATENCY == 1) ? ACCESS : WAIT;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - CNT_WIDTH'(1);
                    if (r_cnt == CNT_WIDTH'(1)) begin
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_ack   <= 1'b1;
                    r_state <= ACK;
                end
                ACK: begin
                    r_ack   <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Write data is only needed at acceptance, so it is captured without reset
    always_ff @(posedge clk) begin
        if (r_state == IDLE && cs_i) begin
            r_wdata <= data_i;
        end
    end

    // The storage access happens on the edge that leaves ACCESS
    assign w_store_en = (r_state == ACCESS);

    line_store #(
        .MEM_LINES  (MEM_LINES),
        .DATA_WIDTH (MEM_DATA_WIDTH)
    ) u_line_store (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_store_en),
        .we    (r_we),
        .index (r_index),
        .wdata (r_wdata),
        .rdata (w_rdata)
    );

    assign ack_o  = r_ack;
    assign data_o = w_rdata;

`ifdef DRAM_LINE_RESPONDER_PROTOCOL_CHECK_EN
    logic [ADDR_WIDTH-1:0] r_chk_addr;
    logic                  r_err;

    // Full request address captured at acceptance for the stability check
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_chk_addr <= '0;
        end else if (r_state == IDLE && cs_i) begin
            r_chk_addr <= addr_i;
        end
    end

    // Sticky violation flag: early cs drop, or addr/we moving while waiting
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if ((r_state == WAIT || r_state == ACCESS) && !cs_i) begin
            r_err <= 1'b1;
        end else if (r_state == WAIT && cs_i &&
                     (addr_i != r_chk_addr || we_i != r_we)) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`endif

endmodule : dram_line_responder
`default_nettype wire

// File: doc/dram_line_responder.md
Name: dram_line_responder

Overview:
- Memory-side responder for the L1 cache's DRAM interface. It accepts cs/we line requests, waits a fixed number of cycles, performs one 256-bit line read or write on internal storage, then pulses ack.
- Serves as the DRAM model behind the L1 cache in system simulation, and as the seat for a future real memory controller.
- Serves one request at a time; it has no queueing.

Parameters:
- addr_width, 32, byte address width.
- mem_data_width, 256, line width in bits (32 bytes, so 5 offset bits).
- mem_lines, 1024, number of lines stored; must be a power of 2.
- latency, 10, cycles from request acceptance to ack; legal range 1..255.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- addr_i  input  addr_width  byte address of the request.
- cs_i  input  1  request strobe; held high until ack_o is seen.
- we_i  input  1  1 = line write, 0 = line read; sampled with cs_i.
- data_i  input  mem_data_width  write line data; sampled at acceptance.
- ack_o  output  1  one-cycle completion pulse.
- data_o  output  mem_data_width  read line data; valid when ack_o is high for a read.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state = IDLE, ack_o = 0, data_o = 0, counter = 0.
  - Storage contents are not cleared.
- Line index = addr_i[log2(mem_lines)+4 : 5].
  - addr_i[4:0] is ignored.
  - Address bits above the index are ignored, so addresses alias and wrap modulo mem_lines.
- States:
  - IDLE: at a clk edge where cs_i = 1, latch the index, we_i and data_i. Load counter = latency-1. If latency = 1, go to ACCESS; otherwise go to WAIT.
  - WAIT: decrement counter each cycle. At the edge where counter = 1, go to ACCESS. Input changes during WAIT are ignored.
  - ACCESS: performs the latched operation at the edge leaving this state.
    - Write: store the latched data into storage[index].
    - Read: data_o <= storage[index].
    - ack_o <= 1; go to ACK.
  - ACK: ack_o = 1 for exactly this cycle. At the next edge ack_o <= 0 and go to IDLE unconditionally; cs_i is not sampled in ACK.
- Timing:
  - Acceptance edge is T0; ack_o is high in cycle T0+latency+1. This is the total latency seen by the requester.
  - The requester drops cs_i in the cycle after ack_o. If cs_i is still high in IDLE, that is a new request (back-to-back is legal).
- data_o holds its last read value until the next read completes; a write does not change data_o.
- A read after a write to the same index, accepted after the write's ack, returns the written data.
- Reset during WAIT or ACCESS aborts the request: no storage write, no ack.
- we_i and data_i are don't-care outside the acceptance edge.

Optional Feature:
- Macro: DRAM_LINE_RESPONDER_PROTOCOL_CHECK_EN.
- With the macro defined, an extra output port err_o (1 bit) exists. err_o is sticky and is cleared only by reset. It sets when either condition occurs:
  - cs_i falls while the state is WAIT or ACCESS.
  - addr_i or we_i changes from the latched value while in WAIT with cs_i = 1.
- err_o has no effect on the transaction, which completes normally.
- Without the macro: no err_o port and no checking logic.

Decomposition:
- Package dram_pkg holds:
  - state enum {IDLE, WAIT, ACCESS, ACK};
  - LINE_OFFSET_BITS = 5;
  - counter width constant (8 bits).
- Sub-module line_store: single-port synchronous array of mem_lines x mem_data_width, with we, index, wdata and registered rdata. The FSM and counter stay in dram_line_responder.

Test Plan:
- Reset → ack_o = 0, data_o = 0, state IDLE; hold cs_i = 0 for 20 cycles → ack_o never rises.
- Write then read, latency = 10:
  - Write addr 0x0000_0040 with data {8{32'hDEADBEEF}} → ack_o high exactly in cycle T0+11.
  - Then read 0x0000_0040 → data_o = {8{32'hDEADBEEF}} with ack_o.
- Offset and alias:
  - Write 0x0000_0020 with data A.
  - Read 0x0000_003C → returns A.
  - Read 0x0000_8020 (mem_lines = 1024, index wraps) → returns A.
- Back-to-back: hold cs_i high across ack with a read at 0x40 and then a write at 0x60 → two ack pulses 12 cycles apart; the write lands and data_o is unchanged.
- Reset mid-WAIT:
  - Issue a write of B to 0x80; drop rst_n at T0+4 → no ack.
  - A later read of 0x80 returns its previous content, not B.
- Protocol check, with DRAM_LINE_RESPONDER_PROTOCOL_CHECK_EN defined: drop cs_i at T0+3 → err_o = 1 from the next cycle, ack still at T0+11, err_o stays 1 until reset.
